// File: rtl/guia_05_sweep_ctrl.sv
// Sweep sequencer for a small combinational gate-under-test.
// Drives every input vector, samples s after a settle time, counts mismatches.
module guia_05_sweep_ctrl #(
  parameter int                 N_IN   = 2,
  parameter int                 SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b1011
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_s,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // counter runs RELOAD..0, giving SETTLE idle cycles per vector
  localparam logic [CW-1:0] RELOAD =
    (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
  localparam logic [N_IN-1:0] LAST = '1;
  localparam state_t ENTRY =
    (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_t            state_q;
  logic [N_IN-1:0]   vec_q;
  logic [CW-1:0]     cnt_q;
  logic [N_IN:0]     err_q;
  logic              fv_q;
  logic [N_IN-1:0]   fvec_q;
  logic              pass_q;
  logic              mis;

  assign mis = dut_s != EXPECT[vec_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ENTRY;
            vec_q   <= '0;
            cnt_q   <= RELOAD;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
            pass_q  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            pass_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          // abort beats the final sample, so no done pulse
          if (abort) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            pass_q  <= 1'b0;
          end else begin
            if (mis) begin
              err_q <= err_q + 1'b1;
              if (!fv_q) begin
                fv_q   <= 1'b1;
                fvec_q <= vec_q;
              end
            end
            if (vec_q == LAST) begin
              state_q <= ST_DONE;
            end else begin
              vec_q   <= vec_q + 1'b1;
              cnt_q   <= RELOAD;
              state_q <= ENTRY;
            end
          end
        end
        ST_DONE: begin
          pass_q  <= (err_q == '0);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dut_in          = vec_q;
  assign busy            = (state_q == ST_SETTLE) ||
                           (state_q == ST_SAMPLE);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fv_q;
  assign first_err_vec   = fvec_q;

endmodule

// File: tb/tb_guia_05_sweep_ctrl.sv
// Randomized scoreboard bench for guia_05_sweep_ctrl.
// Instance 0 uses SETTLE=1, instance 1 uses SETTLE=0.
module tb_guia_05_sweep_ctrl;

  localparam logic [3:0] EXP = 4'b1011;

  typedef struct packed {
    logic [2:0] err;
    logic       fv;
    logic [1:0] fvec;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      st;
  logic [1:0]      ab;
  logic [1:0][3:0] tbl_v;
  logic [1:0]      s_v;
  logic [1:0][1:0] in_v;
  logic [1:0]      busy_v;
  logic [1:0]      done_v;
  logic [1:0]      pass_v;
  logic [1:0][2:0] err_v;
  logic [1:0]      fv_v;
  logic [1:0][1:0] fvec_v;

  assign s_v[0] = tbl_v[0][in_v[0]];
  assign s_v[1] = tbl_v[1][in_v[1]];

  guia_05_sweep_ctrl #(.N_IN(2), .SETTLE(1), .EXPECT(EXP)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]),
    .dut_s(s_v[0]), .dut_in(in_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
    .first_err_valid(fv_v[0]), .first_err_vec(fvec_v[0])
  );

  guia_05_sweep_ctrl #(.N_IN(2), .SETTLE(0), .EXPECT(EXP)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]),
    .dut_s(s_v[1]), .dut_in(in_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
    .first_err_valid(fv_v[1]), .first_err_vec(fvec_v[1])
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int spv(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // truth table of s = ~(a & ~b), a = MSB of the vector
  function automatic logic [3:0] gate_tbl();
    logic [3:0] t;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] x;
      x = 2'(v);
      t[v] = ~(x[1] & ~x[0]);
    end
    return t;
  endfunction

  function automatic exp_t model(logic [3:0] t);
    exp_t e;
    e = '0;
    for (int v = 0; v < 4; v++) begin
      if (t[v] != EXP[v]) begin
        if (!e.fv) begin
          e.fv   = 1'b1;
          e.fvec = 2'(v);
        end
        e.err = e.err + 3'd1;
      end
    end
    e.pass = (e.err == 3'd0);
    return e;
  endfunction

  task automatic push(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // monitor: vector trace, done latency, results, pass
  initial begin : monitor
    int   bcnt [2];
    logic pb   [2];
    logic pp   [2];
    logic pexp [2];
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) begin
      bcnt[d] = 0; pb[d] = 0; pp[d] = 0; pexp[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          pb[d] = 0;
          pp[d] = 0;
        end else begin
          if (busy_v[d]) begin
            if (!pb[d]) bcnt[d] = 0;
            chk($sformatf("vec%0d", d), in_v[d],
                bcnt[d] / spv(d));
            bcnt[d]++;
          end
          if (pp[d]) begin
            chk($sformatf("pass%0d", d), pass_v[d], pexp[d]);
            pp[d] = 0;
          end
          if (done_v[d]) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
              checks++;
              errors++;
              $display("FAIL done%0d: unexpected done got 1 expected 0",
                       d);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("lat%0d", d), pb[d] ? bcnt[d] : -1,
                  4 * spv(d));
              chk($sformatf("err%0d", d), err_v[d], e.err);
              chk($sformatf("fv%0d", d), fv_v[d], e.fv);
              if (e.fv)
                chk($sformatf("fvec%0d", d), fvec_v[d], e.fvec);
              pp[d]   = 1;
              pexp[d] = e.pass;
            end
          end
          pb[d] = busy_v[d];
        end
      end
    end
  end

  task automatic chk_zero(int d, string tag);
    chk({tag, "_in"}, in_v[d], 0);
    chk({tag, "_busy"}, busy_v[d], 0);
    chk({tag, "_done"}, done_v[d], 0);
    chk({tag, "_pass"}, pass_v[d], 0);
    chk({tag, "_err"}, err_v[d], 0);
    chk({tag, "_fv"}, fv_v[d], 0);
    chk({tag, "_fvec"}, fvec_v[d], 0);
  endtask

  task automatic wait_done(int d);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_v[d]) break;
    end
    if (k == 100) begin
      checks++;
      errors++;
      $display("FAIL timeout%0d: done got 0 expected 1", d);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(int d);
    @(posedge clk); #1;
    st[d] = 1'b1;
    @(posedge clk); #1;
    st[d] = 1'b0;
  endtask

  task automatic sweep(int d, logic [3:0] t, bit noisy);
    tbl_v[d] = t;
    push(d, model(t));
    pulse_start(d);
    if (noisy) begin
      for (int k = 0; k < 3 * spv(d); k++) begin
        st[d] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      st[d] = 1'b0;
    end
    wait_done(d);
  endtask

  task automatic wait_vec(int d, int v);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy_v[d] && in_v[d] == 2'(v)) break;
    end
    if (k == 100) begin
      checks++;
      errors++;
      $display("FAIL wait_vec%0d: vector got none expected %0d", d, v);
    end
  endtask

  initial begin : stim
    logic [3:0] good;
    int         d;
    good  = gate_tbl();
    rst_n = 1'b0;
    st    = '0;
    ab    = '0;
    tbl_v = '0;
    #2;
    chk_zero(0, "rst0a");
    chk_zero(1, "rst0b");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    sweep(0, good, 0);
    sweep(0, 4'b1111, 0);
    sweep(0, 4'b0000, 0);
    sweep(1, good, 0);
    sweep(1, 4'b1111, 0);
    sweep(1, 4'b0000, 0);

    // start and abort together in IDLE: start wins
    tbl_v[0] = good;
    push(0, model(good));
    @(posedge clk); #1;
    st[0] = 1'b1; ab[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0; ab[0] = 1'b0;
    wait_done(0);

    // abort on vector 1 with s stuck-at-0
    tbl_v[0] = 4'b0000;
    pulse_start(0);
    wait_vec(0, 1);
    ab[0] = 1'b1;
    @(posedge clk); #1;
    ab[0] = 1'b0;
    @(negedge clk);
    chk("abA_busy", busy_v[0], 0);
    chk("abA_done", done_v[0], 0);
    chk("abA_in", in_v[0], 0);
    chk("abA_pass", pass_v[0], 0);
    chk("abA_err", err_v[0], 1);
    chk("abA_fv", fv_v[0], 1);
    chk("abA_fvec", fvec_v[0], 0);
    repeat (4) @(negedge clk);
    sweep(0, good, 0);

    // abort during the final sample of a SETTLE=0 sweep
    tbl_v[1] = good;
    pulse_start(1);
    wait_vec(1, 3);
    ab[1] = 1'b1;
    @(posedge clk); #1;
    ab[1] = 1'b0;
    @(negedge clk);
    chk("abB_done", done_v[1], 0);
    chk("abB_busy", busy_v[1], 0);
    chk("abB_in", in_v[1], 0);
    chk("abB_pass", pass_v[1], 0);
    repeat (3) @(negedge clk);

    // start held high: one sweep per IDLE entry
    tbl_v[0] = 4'($urandom_range(0, 15));
    push(0, model(tbl_v[0]));
    push(0, model(tbl_v[0]));
    @(posedge clk); #1;
    st[0] = 1'b1;
    wait_done(0);
    @(posedge clk); #1;
    st[0] = 1'b0;
    wait_done(0);

    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 1));
      sweep(d, 4'($urandom_range(0, 15)), 1);
    end

    // async reset in the middle of a sweep
    tbl_v[1] = 4'($urandom_range(0, 15));
    push(1, model(tbl_v[1]));
    pulse_start(1);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_zero(0, "rst1a");
    chk_zero(1, "rst1b");
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep(1, 4'($urandom_range(0, 15)), 0);
    sweep(0, 4'($urandom_range(0, 15)), 0);
    repeat (3) @(negedge clk);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
